cache_arbiter: RTL
==================

Name: cache_arbiter

Overview:
- Shares the single physical-memory line port (cacheline adaptor side) between the I-cache miss port and the D-cache miss/writeback port of the mp3 pipelined core.
- Sits between both caches' line-granular pmem interfaces and the one line interface that feeds pmem_read/pmem_write/pmem_addr.
- Serializes line transactions one at a time; breaks simultaneous requests round-robin; returns response and line data to the granted cache only.

Parameters:
- LINE_WIDTH, 256, bits per cache line on all data ports.
- ADDR_WIDTH, 32, line-aligned physical address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line read request
- i_addr  in  ADDR_WIDTH  I-cache line address
- i_rdata  out  LINE_WIDTH  line returned to I-cache
- i_resp  out  1  I-cache transaction complete
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line writeback request
- d_addr  in  ADDR_WIDTH  D-cache line address
- d_wdata  in  LINE_WIDTH  writeback line
- d_rdata  out  LINE_WIDTH  line returned to D-cache
- d_resp  out  1  D-cache transaction complete
- mem_read  out  1  read to line memory
- mem_write  out  1  write to line memory
- mem_addr  out  ADDR_WIDTH  line address to memory
- mem_wdata  out  LINE_WIDTH  line write data
- mem_rdata  in  LINE_WIDTH  line read data
- mem_resp  in  1  memory transaction complete

Behaviour:
- FSM states: IDLE, SERVE_I, SERVE_D, DONE. Register last_grant (INST/DATA).
- Reset: state=IDLE, last_grant=INST, mem_read=mem_write=0, mem_addr=0, mem_wdata=0, i_resp=d_resp=0.
- IDLE:
  - Only i_read asserted -> SERVE_I.
  - Only (d_read|d_write) asserted -> SERVE_D.
  - Both requesting -> grant the side opposite last_grant. First tie after reset goes to DATA.
  - No request -> stay in IDLE.
  - On grant, latch the address; for D, also latch wdata and op. If d_write and d_read are both high, write wins.
- SERVE_x:
  - mem_read/mem_write, mem_addr, mem_wdata are registered. They assert in the cycle after the grant decision (request seen at cycle N -> mem_* valid at N+1).
  - They hold constant until mem_resp.
- On mem_resp (cycle M):
  - Combinationally assert the granted side's resp.
  - Drive mem_rdata to the granted side's rdata in cycle M only. rdata of the non-granted side = 0.
  - Update last_grant; deassert mem_read/mem_write at M+1; go to DONE.
- DONE:
  - One turnaround cycle; no grant. This lets the served cache drop its request so a stale request is not re-granted.
  - Then IDLE.
  - Minimum back-to-back spacing: grant-to-grant = memory latency + 3 cycles.
- mem_resp arriving in IDLE or DONE: ignored, no resp forwarded.
- Requests must stay asserted and stable until resp. Changes to address or data mid-transaction are ignored, because the latched copy is used.
- Reset mid-transaction:
  - Next edge returns to IDLE with all outputs deasserted.
  - Any pending memory transaction is abandoned; the memory side shares the same rst.
- i_resp and d_resp are never high in the same cycle.

Decomposition:
- Shared package (arbiter_types): enum arb_state_t {IDLE, SERVE_I, SERVE_D, DONE}; enum grant_t {GRANT_INST, GRANT_DATA}; LINE_WIDTH and ADDR_WIDTH default constants.
- No sub-module needed. The FSM plus latched request registers form one module.

Test Plan:
1. I-only: i_read=1, i_addr=0x0000_0060, memory responds after 5 cycles with line 0xA5..A5 -> mem_read=1 with mem_addr=0x60 from cycle 1; i_resp=1 and i_rdata=0xA5..A5 in the resp cycle; d_resp stays 0.
2. D writeback: d_write=1, d_addr=0x0000_1000, d_wdata=0xDEAD..BEEF -> mem_write=1 with matching addr/wdata; mem_read=0 throughout; d_resp pulses once.
3. Tie after reset: i_read and d_read both asserted at cycle 0 -> D served first. After DONE, I served with mem_addr equal to i_addr. Next tie -> D again (alternation verified over 4 ties).
4. Reset mid-op: assert rst during SERVE_I before mem_resp -> next cycle mem_read=0, i_resp=0, state IDLE. A later mem_resp is not forwarded.
5. Stale request: hold d_read high one extra cycle after d_resp -> no second mem_read during DONE; re-granted only if still high in IDLE.
6. Read+write conflict: d_read=d_write=1 -> only mem_write asserted.

Source files
------------

// File: rtl/cache_arbiter_pkg.sv
// rtl/cache_arbiter_pkg.sv - shared types and default widths for the cache line arbiter
//
// Purpose: states, grant encoding and default widths used by the arbiter
//          and its bus interface.
// Contents:
//   ARB_LINE_WIDTH  default bits per cache line
//   ARB_ADDR_WIDTH  default line address width
//   arb_state_t     IDLE / SERVE_I / SERVE_D / DONE
//   grant_t         GRANT_INST / GRANT_DATA (round-robin history)
package arbiter_types;

  localparam int ARB_LINE_WIDTH = 256;
  localparam int ARB_ADDR_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter_if.sv
// rtl/cache_arbiter_if.sv - line-granular bus bundle between the caches, the arbiter and line memory
//
// Purpose: groups the I-cache, D-cache and line-memory signals of the arbiter.
// Modports:
//   slave   the arbiter: accepts cache requests, issues memory transactions
//   master  the environment: drives cache requests and memory responses
// Signals:
//   i_read/i_addr -> i_rdata/i_resp             I-cache miss port
//   d_read/d_write/d_addr/d_wdata -> d_rdata/d_resp   D-cache miss/writeback port
//   mem_read/mem_write/mem_addr/mem_wdata -> mem_rdata/mem_resp   line memory
interface cache_arbiter_if
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH = ARB_LINE_WIDTH,
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
) ();

  logic                  i_read;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic [LINE_WIDTH-1:0] i_rdata;
  logic                  i_resp;

  logic                  d_read;
  logic                  d_write;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [LINE_WIDTH-1:0] d_wdata;
  logic [LINE_WIDTH-1:0] d_rdata;
  logic                  d_resp;

  logic                  mem_read;
  logic                  mem_write;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [LINE_WIDTH-1:0] mem_wdata;
  logic [LINE_WIDTH-1:0] mem_rdata;
  logic                  mem_resp;

  modport slave (
    input  i_read, i_addr,
    output i_rdata, i_resp,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_resp,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_resp
  );

  modport master (
    output i_read, i_addr,
    input  i_rdata, i_resp,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_resp,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_resp
  );

endinterface

// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - round-robin arbiter sharing one line-memory port between I-cache and D-cache
//
// Purpose: serializes line transactions from the I-cache miss port and the
//          D-cache miss/writeback port onto a single line-memory port.
//          Simultaneous requests alternate by the side served last; the
//          memory response and line data return to the granted cache only.
// Ports:
//   clk   system clock
//   rst   synchronous, active-high reset
//   bus   cache_arbiter_if.slave (cache request ports and line-memory port)
module cache_arbiter
  import arbiter_types::*;
#(
  parameter int LINE_WIDTH = ARB_LINE_WIDTH,
  parameter int ADDR_WIDTH = ARB_ADDR_WIDTH
) (
  input logic            clk,
  input logic            rst,
  cache_arbiter_if.slave bus
);

  arb_state_t state;
  arb_state_t state_n;
  grant_t     last_grant;

  logic                  i_req;
  logic                  d_req;
  logic                  pick_d;
  logic                  grant_i;
  logic                  grant_d;
  logic                  i_resp_c;
  logic                  d_resp_c;

  // The memory-side outputs double as the latched copy of the granted
  // request, so later changes on the cache ports cannot leak into an
  // in-flight transaction.
  logic                  mem_read_q;
  logic                  mem_write_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [LINE_WIDTH-1:0] mem_wdata_q;

  assign i_req = bus.i_read;
  assign d_req = bus.d_read | bus.d_write;

  // D wins when it is the only requester, or on a tie when I was served
  // last. last_grant resets to INST, so the first tie goes to D.
  assign pick_d = d_req && (!i_req || (last_grant == GRANT_INST));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    grant_i  = 1'b0;
    grant_d  = 1'b0;
    i_resp_c = 1'b0;
    d_resp_c = 1'b0;
    case (state)
      IDLE: begin
        if (pick_d) begin
          grant_d = 1'b1;
          state_n = SERVE_D;
        end else if (i_req) begin
          grant_i = 1'b1;
          state_n = SERVE_I;
        end
      end
      SERVE_I: begin
        if (bus.mem_resp) begin
          i_resp_c = 1'b1;
          state_n  = DONE;
        end
      end
      SERVE_D: begin
        if (bus.mem_resp) begin
          d_resp_c = 1'b1;
          state_n  = DONE;
        end
      end
      // Turnaround: gives the served cache a cycle to drop its request
      // before requests are looked at again.
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      last_grant  <= GRANT_INST;
    end else if (grant_i) begin
      mem_read_q  <= 1'b1;
      mem_write_q <= 1'b0;
      mem_addr_q  <= bus.i_addr;
    end else if (grant_d) begin
      // A writeback takes priority over a read raised in the same cycle.
      mem_write_q <= bus.d_write;
      mem_read_q  <= ~bus.d_write;
      mem_addr_q  <= bus.d_addr;
      mem_wdata_q <= bus.d_wdata;
    end else if (i_resp_c || d_resp_c) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      last_grant  <= d_resp_c ? GRANT_DATA : GRANT_INST;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

  // Responses are only decoded in the matching SERVE state, so a stray
  // mem_resp in IDLE or DONE never reaches either cache, and the two
  // resp outputs are mutually exclusive by construction.
  assign bus.i_resp  = i_resp_c;
  assign bus.d_resp  = d_resp_c;
  assign bus.i_rdata = i_resp_c ? bus.mem_rdata : '0;
  assign bus.d_rdata = d_resp_c ? bus.mem_rdata : '0;

endmodule
